// File: rtl/ling_subtractor_pipe_if.sv
// Operand/result handshake bundle for the Ling subtractor pipeline.
// The master side issues operands and consumes results; the slave side is the pipeline.
interface ling_subtractor_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             bin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] DIFF_o;
  logic             bout_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  in_valid_i, A_i, B_i, bin_i, out_ready_i,
    output in_ready_o, out_valid_o, DIFF_o, bout_o, ovf_o, zero_o
  );

  modport master (
    output in_valid_i, A_i, B_i, bin_i, out_ready_i,
    input  in_ready_o, out_valid_o, DIFF_o, bout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/ling_subtractor_pipe.sv
// Two-stage pipelined subtractor: DIFF = A - B - bin (mod 2^WIDTH).
// Stage 1 resolves the low SPLIT bits and registers the mid carry; stage 2
// finishes the upper bits from that carry and registers result and flags.
// Subtraction is done as A + ~B + ~bin, so the chain carry-in is ~bin and the
// final carry-out is the inverted borrow.
module ling_subtractor_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  ling_subtractor_pipe_if.slave bus
);

  localparam int HI = WIDTH - SPLIT;

  logic [WIDTH-1:0] b_n;

  logic [SPLIT-1:0] lo_diff;
  logic             lo_h;
  logic             lo_chain;

  logic             s1_valid;
  logic [SPLIT-1:0] s1_diff_lo;
  logic             s1_h_mid;
  logic [HI-1:0]    s1_a_hi;
  logic [HI-1:0]    s1_bn_hi;
  logic             s1_a_msb;

  logic [HI-1:0]    hi_diff;
  logic             hi_h;
  logic             hi_chain;
  logic [WIDTH-1:0] diff_full;
  logic             ovf_nxt;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_diff;
  logic             s2_bout;
  logic             s2_ovf;
  logic             s2_zero;

  logic             s2_ready;
  logic             s1_ready;

  assign b_n = ~bus.B_i;

  // Ready chains back combinationally so a full pipe still streams at one beat per cycle.
  assign s2_ready       = ~s2_valid | bus.out_ready_i;
  assign s1_ready       = ~s1_valid | s2_ready;
  assign bus.in_ready_o = s1_ready;

  // Low-half carry chain on (A, ~B) seeded with ~bin.
  always_comb begin
    lo_diff  = '0;
    lo_chain = ~bus.bin_i;
    for (int i = 0; i < SPLIT; i++) begin
      lo_diff[i] = (bus.A_i[i] ^ b_n[i]) ^ lo_chain;
      lo_chain   = (bus.A_i[i] & b_n[i]) | ((bus.A_i[i] | b_n[i]) & lo_chain);
    end
    lo_h = lo_chain;
  end

  // Stage 1 register: loads only on an accept; the valid bit follows the upstream offer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_h_mid   <= 1'b0;
      s1_a_hi    <= '0;
      s1_bn_hi   <= '0;
      s1_a_msb   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_diff_lo <= lo_diff;
        s1_h_mid   <= lo_h;
        s1_a_hi    <= bus.A_i[WIDTH-1:SPLIT];
        s1_bn_hi   <= b_n[WIDTH-1:SPLIT];
        s1_a_msb   <= bus.A_i[WIDTH-1];
      end
    end
  end

  // Upper-half carry chain continuing from the registered mid carry.
  always_comb begin
    hi_diff  = '0;
    hi_chain = s1_h_mid;
    for (int i = 0; i < HI; i++) begin
      hi_diff[i] = (s1_a_hi[i] ^ s1_bn_hi[i]) ^ hi_chain;
      hi_chain   = (s1_a_hi[i] & s1_bn_hi[i]) | ((s1_a_hi[i] | s1_bn_hi[i]) & hi_chain);
    end
    hi_h = hi_chain;
  end

  assign diff_full = {hi_diff, s1_diff_lo};
  // Operand signs differ exactly when A's msb equals the inverted B msb.
  assign ovf_nxt   = (s1_a_msb == s1_bn_hi[HI-1]) & (diff_full[WIDTH-1] != s1_a_msb);

  // Stage 2 register: holds the presented result until the downstream takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_diff  <= '0;
      s2_bout  <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_diff <= diff_full;
        s2_bout <= ~hi_h;
        s2_ovf  <= ovf_nxt;
        s2_zero <= (diff_full == '0);
      end
    end
  end

  assign bus.out_valid_o = s2_valid;
  assign bus.DIFF_o      = s2_diff;
  assign bus.bout_o      = s2_bout;
  assign bus.ovf_o       = s2_ovf;
  assign bus.zero_o      = s2_zero;

endmodule

// File: tb/tb_ling_subtractor_pipe.sv
// Scoreboard bench for ling_subtractor_pipe: the driver pushes expected
// results on every accept, the monitor pops and compares on every output transfer.
module tb_ling_subtractor_pipe;

  logic clk_i;
  logic rst_i;

  ling_subtractor_pipe_if #(.WIDTH(32)) ifc ();

  ling_subtractor_pipe #(.WIDTH(32), .SPLIT(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  int acc   = 0;
  logic rnd_ready = 1'b0;

  // {diff[31:0], bout, ovf, zero}
  logic [34:0] sb[$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] w;
    logic [31:0] d;
    logic        ov;
    w  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    d  = w[31:0];
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    return {d, w[32], ov, (d == 32'd0)};
  endfunction

  // Offer one beat until accepted; the expected result is queued at the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin, input logic [34:0] exp);
    int n;
    n = 0;
    ifc.in_valid_i = 1'b1;
    ifc.A_i        = a;
    ifc.B_i        = b;
    ifc.bin_i      = bin;
    forever begin
      @(negedge clk_i);
      if (ifc.in_ready_o) begin
        sb.push_back(exp);
        acc++;
        @(posedge clk_i);
        #1;
        break;
      end
      @(posedge clk_i);
      #1;
      n++;
      if (n > 500) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    ifc.in_valid_i = 1'b0;
    ifc.A_i        = $urandom;
    ifc.B_i        = $urandom;
    ifc.bin_i      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ifc.out_valid_o) && n < 2000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares each output transfer to the queue head and checks stall stability.
  initial begin
    logic        hold_v;
    logic [34:0] hold_val;
    logic [34:0] e;
    hold_v   = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          chk("hold_stable", {ifc.out_valid_o, ifc.DIFF_o, ifc.bout_o, ifc.ovf_o, ifc.zero_o},
              {1'b1, hold_val});
        if (ifc.out_valid_o && ifc.out_ready_i) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got DIFF=%h with no result expected", ifc.DIFF_o);
          end else begin
            e = sb.pop_front();
            chk("result", {ifc.DIFF_o, ifc.bout_o, ifc.ovf_o, ifc.zero_o}, e);
          end
          hold_v = 1'b0;
        end else if (ifc.out_valid_o) begin
          hold_v   = 1'b1;
          hold_val = {ifc.DIFF_o, ifc.bout_o, ifc.ovf_o, ifc.zero_o};
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  // Random backpressure, enabled only during the random phase.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rnd_ready) ifc.out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    rst_i           = 1'b1;
    ifc.in_valid_i  = 1'b0;
    ifc.A_i         = '0;
    ifc.B_i         = '0;
    ifc.bin_i       = 1'b0;
    ifc.out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    chk("rst_out_valid", 64'(ifc.out_valid_o), 64'd0);
    chk("rst_outputs", {ifc.DIFF_o, ifc.bout_o, ifc.ovf_o, ifc.zero_o}, 64'd0);
    chk("rst_in_ready", 64'(ifc.in_ready_o), 64'd1);

    // Single beat: not visible one cycle after accept, visible after the second stage.
    send(32'd5, 32'd3, 1'b0, {32'h0000_0002, 1'b0, 1'b0, 1'b0});
    chk("lat_stage1", 64'(ifc.out_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk("lat_stage2", 64'(ifc.out_valid_o), 64'd1);
    drain();

    // Directed vectors, back-to-back with out_ready held high.
    send(32'h0000_0000, 32'h0000_0001, 1'b0, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    send(32'h0000_0007, 32'h0000_0007, 1'b1, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    send(32'h1234_ABCD, 32'h1234_ABCD, 1'b0, {32'h0000_0000, 1'b0, 1'b0, 1'b1});
    send(32'h8000_0000, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
    send(32'h0001_0000, 32'h0000_0001, 1'b0, {32'h0000_FFFF, 1'b0, 1'b0, 1'b0});
    send(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, {32'hFFFE_0001, 1'b0, 1'b0, 1'b0});
    send(32'h0000_0000, 32'h0000_0000, 1'b1, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    send(32'h0000_0000, 32'h8000_0000, 1'b0, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    send(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    send(32'h0001_0000, 32'h0000_0000, 1'b1, {32'h0000_FFFF, 1'b0, 1'b0, 1'b0});
    drain();

    // Stall: four beats offered with the output blocked; only two fit.
    ifc.out_ready_i = 1'b0;
    n = acc;
    fork
      begin
        send(32'd1000, 32'd1, 1'b0, {32'h0000_03E7, 1'b0, 1'b0, 1'b0});
        send(32'd1000, 32'd2, 1'b0, {32'h0000_03E6, 1'b0, 1'b0, 1'b0});
        send(32'd1000, 32'd3, 1'b0, {32'h0000_03E5, 1'b0, 1'b0, 1'b0});
        send(32'd1000, 32'd4, 1'b0, {32'h0000_03E4, 1'b0, 1'b0, 1'b0});
      end
      begin
        repeat (5) @(posedge clk_i);
        #2;
        chk("stall_accepted", 64'(acc - n), 64'd2);
        chk("stall_in_ready", 64'(ifc.in_ready_o), 64'd0);
        ifc.out_ready_i = 1'b1;
      end
    join
    drain();

    // Random valid gaps and random backpressure against the arithmetic model.
    rnd_ready = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        bi;
      a  = $urandom;
      b  = (k % 8 == 0) ? a : $urandom;
      bi = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
      send(a, b, bi, model(a, b, bi));
    end
    rnd_ready = 1'b0;
    @(posedge clk_i);
    #1;
    ifc.out_ready_i = 1'b1;
    drain();

    // Reset with both stages full: held beats and the reset-cycle offer must vanish.
    ifc.out_ready_i = 1'b0;
    send(32'h0000_0010, 32'h0000_0001, 1'b0, {32'h0000_000F, 1'b0, 1'b0, 1'b0});
    send(32'h0000_0020, 32'h0000_0001, 1'b0, {32'h0000_001F, 1'b0, 1'b0, 1'b0});
    chk("full_in_ready", 64'(ifc.in_ready_o), 64'd0);
    chk("full_out_valid", 64'(ifc.out_valid_o), 64'd1);
    rst_i           = 1'b1;
    ifc.in_valid_i  = 1'b1;
    ifc.A_i         = 32'h0000_0099;
    ifc.B_i         = 32'h0000_0001;
    ifc.out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i          = 1'b0;
    ifc.in_valid_i = 1'b0;
    sb.delete();
    chk("mid_rst_out_valid", 64'(ifc.out_valid_o), 64'd0);
    chk("mid_rst_outputs", {ifc.DIFF_o, ifc.bout_o, ifc.ovf_o, ifc.zero_o}, 64'd0);
    chk("mid_rst_in_ready", 64'(ifc.in_ready_o), 64'd1);
    repeat (4) @(posedge clk_i);
    #1;
    chk("post_rst_idle", 64'(ifc.out_valid_o), 64'd0);

    send(32'h0000_0003, 32'h0000_0005, 1'b0, {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
